// File: rtl/display_pkg.sv
// Shared widths, index-width helper and blank anode pattern for the 7-segment scan logic.
package display_pkg;

    localparam int NIBBLE_W  = 4;
    localparam int DIGIT_MAX = 8;

    // All anodes high switches every digit off; callers slice the low NUM_DIGITS bits.
    localparam logic [DIGIT_MAX-1:0] BLANK_AN = '1;

    // Width needed to count 0..v-1, never less than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1 and emits a registered one-cycle tick per digit slot.
// tc is the combinational terminal count, so the caller can advance state on the same edge the tick rises.
module scan_prescaler
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick,
    output logic tc
);

    localparam int CNT_W = clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             w_tc;

    assign w_tc = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tc;
            r_cnt  <= w_tc ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = r_tick;
    assign tc   = w_tc;

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed N-digit 7-segment driver: rotates a one-hot select per refresh slot and muxes a per-scan snapshot.
// Optional LEADING_ZERO_BLANK_EN additionally blanks leading zero digits above digit 0.
module digit_scan_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] n,
    input  logic [NUM_DIGITS-1:0]          dp_in,
    input  logic [NUM_DIGITS-1:0]          enable_mask,
    output logic [NUM_DIGITS-1:0]          sel,
    output logic [NUM_DIGITS-1:0]          an,
    output logic [NIBBLE_W-1:0]            h,
    output logic                           dp,
    output logic [clog2(NUM_DIGITS)-1:0]   digit_idx,
    output logic                           tick
);

    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [IDX_W-1:0]               r_idx;
    logic [NIBBLE_W*NUM_DIGITS-1:0] r_snap_n;
    logic [NUM_DIGITS-1:0]          r_snap_dp;
    logic                           r_snap_vld;

    logic                  w_tc;
    logic                  w_wrap;
    logic                  w_blank;
    logic [NUM_DIGITS-1:0] w_sel;

    scan_prescaler #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .tick (tick),
        .tc   (w_tc)
    );

    assign w_wrap = w_tc && (r_idx == LAST_IDX);

    // Snapshot only at scan boundaries so a single scan never mixes old and new digits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx      <= '0;
            r_snap_n   <= '0;
            r_snap_dp  <= '0;
            r_snap_vld <= 1'b0;
        end else begin
            if (w_tc) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
            if (!r_snap_vld || w_wrap) begin
                r_snap_n   <= n;
                r_snap_dp  <= dp_in;
                r_snap_vld <= 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] w_lz;

    // Walk down from the top digit; suppression ends at the first nonzero nibble or set dp.
    always_comb begin : lz_scan
        logic run;
        w_lz = '0;
        run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            run     = run && (r_snap_n[NIBBLE_W*k +: NIBBLE_W] == '0) && !r_snap_dp[k];
            w_lz[k] = run;
        end
    end

    assign w_blank = !enable_mask[r_idx] || w_lz[r_idx];
`else
    assign w_blank = !enable_mask[r_idx];
`endif

    assign w_sel     = NUM_DIGITS'(1) << r_idx;
    assign sel       = w_sel;
    assign digit_idx = r_idx;
    assign an        = w_blank ? BLANK_AN[NUM_DIGITS-1:0] : ~w_sel;
    assign h         = r_snap_vld ? r_snap_n[NIBBLE_W*r_idx +: NIBBLE_W] : '0;
    assign dp        = (w_blank || !r_snap_vld) ? 1'b1 : !r_snap_dp[r_idx];

endmodule

// File: tb/tb_digit_scan_mux.sv
// Directed bench for digit_scan_mux (4 digits, 4 cycles/slot) with a time-based reference model.
module tb_digit_scan_mux;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  n;
    logic [3:0]   dp_in;
    logic [3:0]   enable_mask;
    logic [3:0]   sel;
    logic [3:0]   an;
    logic [3:0]   h;
    logic         dp;
    logic [1:0]   digit_idx;
    logic         tick;

    int total = 0;
    int bad   = 0;

    digit_scan_mux #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .n          (n),
        .dp_in      (dp_in),
        .enable_mask(enable_mask),
        .sel        (sel),
        .an         (an),
        .h          (h),
        .dp         (dp),
        .digit_idx  (digit_idx),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: elapsed cycles since reset plus the display values captured for the current scan.
    int          t       = 0;
    bit          m_vld   = 1'b0;
    bit          started = 1'b0;
    logic [15:0] m_n     = '0;
    logic [3:0]  m_dp    = '0;

    always @(posedge clk) begin
        if (reset) begin
            t       = 0;
            m_vld   = 1'b0;
            m_n     = '0;
            m_dp    = '0;
            started = 1'b1;
        end else begin
            if (!m_vld || ((t + 1) % (N * D) == 0)) begin
                m_n   = n;
                m_dp  = dp_in;
                m_vld = 1'b1;
            end
            t = t + 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            int          e_idx;
            logic [3:0]  e_sel;
            logic [3:0]  e_h;
            logic        blank;
            logic        e_dp;
            e_idx = (t / D) % N;
            e_sel = 4'(1 << e_idx);
            e_h   = m_vld ? 4'((m_n >> (4 * e_idx)) & 16'hF) : 4'h0;
            blank = !enable_mask[e_idx];
`ifdef LEADING_ZERO_BLANK_EN
            if (e_idx > 0) begin
                bit allz;
                allz = 1'b1;
                for (int j = e_idx; j < N; j++) begin
                    if (((m_n >> (4 * j)) & 16'hF) != 0 || m_dp[j]) allz = 1'b0;
                end
                blank = blank || allz;
            end
`endif
            e_dp = (blank || !m_vld) ? 1'b1 : !m_dp[e_idx];
            chk("model_sel", {28'h0, sel}, {28'h0, e_sel});
            chk("model_idx", {30'h0, digit_idx}, e_idx);
            chk("model_h", {28'h0, h}, {28'h0, e_h});
            chk("model_an", {28'h0, an}, {28'h0, (blank ? 4'hF : ~e_sel)});
            chk("model_dp", {31'h0, dp}, {31'h0, e_dp});
            chk("model_tick", {31'h0, tick}, {31'h0, (t > 0 && t % D == 0)});
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        n           = 16'h1234;
        dp_in       = 4'h0;
        enable_mask = 4'hF;
        step(2);
        chk("rst_sel", {28'h0, sel}, 32'h1);
        chk("rst_tick", {31'h0, tick}, 32'h0);
        reset = 1'b0;

        // Basic rotation
        chk("pre_snap_h", {28'h0, h}, 32'h0);
        chk("pre_snap_dp", {31'h0, dp}, 32'h1);
        step(1);
        chk("t1_sel", {28'h0, sel}, 32'h1);
        chk("t1_an", {28'h0, an}, 32'hE);
        chk("t1_h", {28'h0, h}, 32'h4);
        step(3);
        chk("t4_sel", {28'h0, sel}, 32'h2);
        chk("t4_h", {28'h0, h}, 32'h3);
        chk("t4_tick", {31'h0, tick}, 32'h1);
        step(1);
        chk("t5_tick", {31'h0, tick}, 32'h0);
        step(3);
        chk("t8_h", {28'h0, h}, 32'h2);
        step(4);
        chk("t12_h", {28'h0, h}, 32'h1);
        step(4);
        chk("t16_wrap_h", {28'h0, h}, 32'h4);
        chk("t16_wrap_sel", {28'h0, sel}, 32'h1);

        // Mid-scan data change is held off until the next scan
        step(4);
        n = 16'hABCD;
        step(4);
        chk("torn_h2", {28'h0, h}, 32'h2);
        step(4);
        chk("torn_h3", {28'h0, h}, 32'h1);
        step(4);
        chk("new_h0", {28'h0, h}, 32'hD);
        step(4);
        chk("new_h1", {28'h0, h}, 32'hC);
        step(4);
        chk("new_h2", {28'h0, h}, 32'hB);
        step(4);
        chk("new_h3", {28'h0, h}, 32'hA);

        // Blanking mask on digit 2 (t=48)
        step(4);
        enable_mask = 4'b1011;
        chk("mask_slot0_an", {28'h0, an}, 32'hE);
        step(8);
        chk("mask_slot2_an", {28'h0, an}, 32'hF);
        chk("mask_slot2_dp", {31'h0, dp}, 32'h1);
        step(3);
        chk("mask_slot2_end_an", {28'h0, an}, 32'hF);
        step(1);
        chk("mask_slot3_an", {28'h0, an}, 32'h7);

        // Decimal point on digit 2, loaded at the t=64 scan
        dp_in       = 4'b0100;
        enable_mask = 4'hF;
        step(8);
        chk("dp_slot1", {31'h0, dp}, 32'h1);
        step(4);
        chk("dp_slot2", {31'h0, dp}, 32'h0);
        step(4);
        chk("dp_slot3", {31'h0, dp}, 32'h1);

        // Reset mid-scan at idx 2, cnt 1 (t=89)
        step(13);
        chk("pre_rst_idx", {30'h0, digit_idx}, 32'h2);
        reset = 1'b1;
        step(1);
        chk("mid_rst_sel", {28'h0, sel}, 32'h1);
        chk("mid_rst_idx", {30'h0, digit_idx}, 32'h0);
        chk("mid_rst_tick", {31'h0, tick}, 32'h0);
        chk("mid_rst_h", {28'h0, h}, 32'h0);
        reset = 1'b0;
        n     = 16'h5678;
        dp_in = 4'h0;
        step(1);
        chk("post_rst_h", {28'h0, h}, 32'h8);
        step(3);
        chk("post_rst_tick", {31'h0, tick}, 32'h1);
        chk("post_rst_h1", {28'h0, h}, 32'h7);

        // Leading zeros
        reset = 1'b1;
        n     = 16'h0050;
        step(1);
        reset = 1'b0;
        step(1);
        chk("lz_d0_h", {28'h0, h}, 32'h0);
        chk("lz_d0_an", {28'h0, an}, 32'hE);
        step(4);
        chk("lz_d1_h", {28'h0, h}, 32'h5);
        chk("lz_d1_an", {28'h0, an}, 32'hD);
        step(4);
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_d2_an", {28'h0, an}, 32'hF);
`else
        chk("lz_d2_an", {28'h0, an}, 32'hB);
`endif
        step(4);
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_d3_an", {28'h0, an}, 32'hF);
`else
        chk("lz_d3_an", {28'h0, an}, 32'h7);
`endif
        n = 16'h0000;
        step(4);
        chk("zero_d0_an", {28'h0, an}, 32'hE);
        chk("zero_d0_h", {28'h0, h}, 32'h0);
        step(4);
`ifdef LEADING_ZERO_BLANK_EN
        chk("zero_d1_an", {28'h0, an}, 32'hF);
`else
        chk("zero_d1_an", {28'h0, an}, 32'hD);
`endif
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
